double_feynman_inverse_pipe: RTL and testbench

//   Streaming inverse of the double Feynman gate (p=a, q=a^b, r=a^c): takes encoded
//   (p,q,r) lanes and recovers (a,b,c) = (p, q^p, r^p). Two-stage valid/ready

---
 rtl/double_feynman_inverse_pipe.sv | 166 ++++++++++++++++
 tb/tb_double_feynman_inverse_pipe.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/double_feynman_inverse_pipe.sv
// Purpose: inverse double Feynman gate, recovers (a,b,c) = (p, q^p, r^p) from encoded lanes.
// Latency: 2 cycles from the cycle a word is presented to the cycle it is on out_*.
// Backpressure: valid/ready, in_ready = s1_adv & !clr (combinational from out_ready, no skid).
module double_feynman_inverse_pipe #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [WIDTH-1:0] in_q,
  input  logic [WIDTH-1:0] in_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [CNT_W-1:0] out_count,
  output logic             err
);

  // One encoded word: the three lanes travel together through both stages.
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
  } enc_t;

  // Stage 1: raw encoded word as accepted from the input port.
  logic s1_valid;
  enc_t s1_dat;

  // Stage 2: decoded lanes (driven out directly) plus the raw word they came from.
  logic             s2_valid;
  logic [WIDTH-1:0] s2_a;
  logic [WIDTH-1:0] s2_b;
  logic [WIDTH-1:0] s2_c;
  enc_t             s2_raw;

  logic [CNT_W-1:0] count_q;
  logic             err_q;

  // Handshake and advance terms.
  logic s2_adv;
  logic s1_adv;
  logic in_fire;
  logic s1_move;
  logic out_fire;

  // Decoded value of the word currently in stage 1.
  logic [WIDTH-1:0] dec_a;
  logic [WIDTH-1:0] dec_b;
  logic [WIDTH-1:0] dec_c;

  // Re-encoded value of the word currently in stage 2.
  enc_t reenc;
  logic mismatch;

  // Advance chain: a stage may take new data when empty or when its consumer drains it.
  always_comb begin
    s2_adv   = !s2_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv && !clr;
    in_fire  = in_valid && in_ready;
    s1_move  = s1_valid && s2_adv;
    out_fire = s2_valid && out_ready;
  end

  // Inverse gate: a passes through, b and c are unmasked by a (bitwise, no carries).
  always_comb begin
    dec_a = s1_dat.p;
    dec_b = s1_dat.q ^ s1_dat.p;
    dec_c = s1_dat.r ^ s1_dat.p;
  end

  // Forward gate applied to the outputs; must reproduce the stored raw word.
  always_comb begin
    reenc.p  = s2_a;
    reenc.q  = s2_a ^ s2_b;
    reenc.r  = s2_a ^ s2_c;
    mismatch = s2_valid && (reenc != s2_raw);
  end

  // Stage 1 occupancy: clr flushes; a new accept refills even while the old word moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 1 data capture on input handshake only (clr blocks it through in_ready).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dat <= '0;
    end else if (in_fire) begin
      s1_dat.p <= in_p;
      s1_dat.q <= in_q;
      s1_dat.r <= in_r;
    end
  end

  // Stage 2 occupancy: takes stage 1's valid whenever it is allowed to advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (clr) begin
      s2_valid <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 data: only loaded on a real move so a stalled output holds stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_a   <= '0;
      s2_b   <= '0;
      s2_c   <= '0;
      s2_raw <= '0;
    end else if (s1_move) begin
      s2_a   <= dec_a;
      s2_b   <= dec_b;
      s2_c   <= dec_c;
      s2_raw <= s1_dat;
    end
  end

  // Transfer counter; clr wins over a coinciding output handshake, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (out_fire) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Sticky round-trip error flag, cleared only by clr or reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (clr) begin
      err_q <= 1'b0;
    end else if (mismatch) begin
      err_q <= 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign out_a     = s2_a;
  assign out_b     = s2_b;
  assign out_c     = s2_c;
  assign out_count = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_double_feynman_inverse_pipe.sv
// Purpose: scoreboard bench for double_feynman_inverse_pipe (main instance plus a CNT_W=3 twin).
// Latency: expected words are queued at input handshake and popped at output handshake.
// Backpressure: out_ready is driven by the stimulus to exercise stalls and flushes.
module tb_double_feynman_inverse_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [0:0] in_p = 1'b0;
  logic [0:0] in_q = 1'b0;
  logic [0:0] in_r = 1'b0;

  logic        in_ready;
  logic        out_valid;
  logic [0:0]  out_a;
  logic [0:0]  out_b;
  logic [0:0]  out_c;
  logic [15:0] out_count;
  logic        err;

  logic        in_ready3;
  logic        out_valid3;
  logic [0:0]  out_a3;
  logic [0:0]  out_b3;
  logic [0:0]  out_c3;
  logic [2:0]  out_count3;
  logic        err3;

  double_feynman_inverse_pipe #(.WIDTH(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_q(in_q), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .out_count(out_count), .err(err)
  );

  double_feynman_inverse_pipe #(.WIDTH(1), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready3),
    .in_p(in_p), .in_q(in_q), .in_r(in_r),
    .out_valid(out_valid3), .out_ready(out_ready),
    .out_a(out_a3), .out_b(out_b3), .out_c(out_c3),
    .out_count(out_count3), .err(err3)
  );

  always #5 clk = ~clk;

  // Hand-computed vectors: {p,q,r} -> {a,b,c} = {p, q^p, r^p}.
  logic [2:0] enc_tab [0:7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [2:0] dec_tab [0:7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b110, 3'b101, 3'b100};

  int         n_vec = 0;
  int         n_bad = 0;
  int         exp_count = 0;
  logic [2:0] sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake; tracks count and err.
  always @(negedge clk) begin
    if (rst_n) begin
      check("err_clear", {31'd0, err}, 32'd0);
      check("out_count", {16'd0, out_count}, exp_count & 32'hffff);
      check("out_count3", {29'd0, out_count3}, exp_count & 32'h7);
      check("in_ready_twin", {31'd0, in_ready3}, {31'd0, in_ready});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got %b%b%b, expected nothing", out_a, out_b, out_c);
        end else begin
          check("out_data", {29'd0, out_a, out_b, out_c}, {29'd0, sb.pop_front()});
        end
        exp_count++;
      end
    end
  end

  // Present one word, wait (bounded) for in_ready, queue its expected decode.
  task automatic send(input logic [2:0] enc, input logic [2:0] dec);
    int t;
    t = 0;
    in_valid = 1'b1;
    {in_p, in_q, in_r} = enc;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
    end else begin
      sb.push_back(dec);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until every queued word has been delivered.
  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words left, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    @(negedge clk);
    check("clr_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    sb.delete();
    exp_count = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0] stall_dat;

    // Reset state.
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {16'd0, out_count}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_data", {29'd0, out_a, out_b, out_c}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: all eight combinations back-to-back.
    for (int i = 0; i < 8; i++) send(enc_tab[i], dec_tab[i]);
    idle();
    drain();
    check("t1_count", {16'd0, out_count}, 32'd8);
    clr_pulse();

    // 2: latency of a lone word (0,1,1) -> (0,1,1).
    in_valid = 1'b1;
    {in_p, in_q, in_r} = 3'b011;
    @(negedge clk);
    check("t2_in_ready0", {31'd0, in_ready}, 32'd1);
    check("t2_valid0", {31'd0, out_valid}, 32'd0);
    sb.push_back(3'b011);
    @(posedge clk);
    #1;
    idle();
    @(negedge clk);
    check("t2_valid1", {31'd0, out_valid}, 32'd0);
    check("t2_in_ready1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("t2_valid2", {31'd0, out_valid}, 32'd1);
    check("t2_in_ready2", {31'd0, in_ready}, 32'd1);
    drain();
    clr_pulse();

    // 3: backpressure, five words with a stalled output.
    out_ready = 1'b0;
    send(enc_tab[5], dec_tab[5]);
    send(enc_tab[2], dec_tab[2]);
    in_valid = 1'b1;
    {in_p, in_q, in_r} = enc_tab[7];
    stall_dat = dec_tab[5];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t3_stall_data", {29'd0, out_a, out_b, out_c}, {29'd0, stall_dat});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(enc_tab[7], dec_tab[7]);
    send(enc_tab[1], dec_tab[1]);
    send(enc_tab[6], dec_tab[6]);
    idle();
    drain();
    check("t3_count", {16'd0, out_count}, 32'd5);

    // 4: clr with two words in flight; the clr-cycle word must not enter.
    out_ready = 1'b0;
    send(enc_tab[4], dec_tab[4]);
    send(enc_tab[3], dec_tab[3]);
    in_valid = 1'b1;
    {in_p, in_q, in_r} = 3'b111;
    clr_pulse();
    idle();
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_valid", {31'd0, out_valid}, 32'd0);
    check("t4_count", {16'd0, out_count}, 32'd0);
    check("t4_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_no_accept", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // 5: nine transfers; the 3-bit twin counter runs ...7,0,1.
    for (int i = 0; i < 9; i++) send(enc_tab[i % 8], dec_tab[i % 8]);
    idle();
    drain();
    check("t5_count3", {29'd0, out_count3}, 32'd1);
    check("t5_count", {16'd0, out_count}, 32'd9);

    // 6: async reset mid-stream, between clock edges.
    out_ready = 1'b0;
    send(enc_tab[6], dec_tab[6]);
    send(enc_tab[5], dec_tab[5]);
    in_valid = 1'b1;
    {in_p, in_q, in_r} = enc_tab[3];
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_valid", {31'd0, out_valid}, 32'd0);
    check("t6_count", {16'd0, out_count}, 32'd0);
    check("t6_count3", {29'd0, out_count3}, 32'd0);
    check("t6_err", {31'd0, err}, 32'd0);
    check("t6_data", {29'd0, out_a, out_b, out_c}, 32'd0);
    sb.delete();
    exp_count = 0;
    idle();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(enc_tab[1], dec_tab[1]);
    send(enc_tab[4], dec_tab[4]);
    send(enc_tab[7], dec_tab[7]);
    idle();
    drain();
    check("t6_restart_count", {16'd0, out_count}, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
